// File: rtl/jpeg_pkg.sv
// Shared types, zigzag-to-raster LUT and coefficient saturation for the dezigzag/dequant block.
package jpeg_pkg;

  localparam int COEF_BITS = 12;
  localparam int QENT_BITS = 8;
  localparam int COEF_MAX  = (1 << (COEF_BITS - 1)) - 1;
  localparam int COEF_MIN  = -(1 << (COEF_BITS - 1));

  typedef logic signed [COEF_BITS-1:0] coef_t;
  typedef logic [QENT_BITS-1:0]        qent_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_EMIT = 2'd2
  } dq_state_e;

  // zigzag scan index -> natural raster index (row*8 + col)
  localparam logic [5:0] ZZ2NAT [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  function automatic coef_t sat_coef(input logic signed [31:0] p);
    if (p > COEF_MAX) return coef_t'(COEF_MAX);
    if (p < COEF_MIN) return coef_t'(COEF_MIN);
    return coef_t'(p[COEF_BITS-1:0]);
  endfunction

endpackage

// File: rtl/jpeg_qt_regs.sv
// Two 64-entry quantisation tables (zigzag order): registered write, combinational read.
module jpeg_qt_regs #(
  parameter int Q_W = 8
) (
  input  logic           clk,
  input  logic           wr_en,
  input  logic           wr_sel,
  input  logic [5:0]     wr_addr,
  input  logic [Q_W-1:0] wr_data,
  input  logic           rd_sel,
  input  logic [5:0]     rd_addr,
  output logic [Q_W-1:0] rd_data
);

  logic [Q_W-1:0] tbl [2][64];

  // Tables are host-loaded and deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) tbl[wr_sel][wr_addr] <= wr_data;
  end

  assign rd_data = tbl[rd_sel][rd_addr];

endmodule

// File: rtl/jpeg_dezigzag_dequant.sv
// Expands (run, level, EOB) symbols into a dequantised 8x8 block in raster order for the IDCT.
// Optional DC prediction on the first symbol of each block: define JPEG_DC_PRED_EN.
//   state | meaning
//   IDLE  | waiting for the first symbol of a block (k treated as 0)
//   FILL  | accepting AC symbols until EOB, pos 63 or run overflow
//   EMIT  | one cycle: masked buffer copied to blk_out, valid_out next cycle
module jpeg_dezigzag_dequant
  import jpeg_pkg::*;
#(
  parameter int CH_W   = 2,
  parameter int COEF_W = 12,
  parameter int Q_W    = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            sym_valid,
  output logic                            sym_ready,
  input  logic [3:0]                      sym_run,
  input  logic signed [COEF_W-1:0]        sym_level,
  input  logic                            sym_eob,
  input  logic [CH_W-1:0]                 sym_chan,
  input  logic                            dc_restart,
  input  logic                            qt_wr,
  input  logic                            qt_sel,
  input  logic [5:0]                      qt_addr,
  input  logic [Q_W-1:0]                  qt_data,
  output logic [7:0][7:0][COEF_W-1:0]     blk_out,
  output logic [CH_W-1:0]                 chan_out,
  output logic                            valid_out,
  output logic                            fmt_err
);

  localparam int P_W = COEF_W + Q_W + 1;

  dq_state_e                state_q, state_d;
  logic                     rdy_q;
  logic [6:0]               k_q, base, pos;
  logic [63:0]              mask_q;
  logic [CH_W-1:0]          chan_q;
  logic                     tsel_q, tsel;
  logic                     acc, first, ovf, done, wr_coef;
  logic [5:0]               nat;
  logic [Q_W-1:0]           q_rd;
  logic signed [COEF_W-1:0] level_eff;
  logic signed [P_W-1:0]    lvl_x, q_x, prod;
  logic signed [COEF_W-1:0] coef_buf [64];

  assign sym_ready = rdy_q && (state_q != ST_EMIT);
  assign acc       = sym_valid && sym_ready;
  assign first     = (state_q == ST_IDLE);
  assign base      = first ? 7'd0 : k_q;
  assign pos       = base + {3'd0, sym_run};
  assign ovf       = pos[6];
  assign nat       = ZZ2NAT[pos[5:0]];
  assign tsel      = first ? (sym_chan != '0) : tsel_q;
  assign wr_coef   = acc && !sym_eob && !ovf;
  assign done      = acc && (sym_eob || ovf || (pos == 7'd63));

  jpeg_qt_regs #(.Q_W(Q_W)) u_qt (
    .clk     (clk),
    .wr_en   (qt_wr),
    .wr_sel  (qt_sel),
    .wr_addr (qt_addr),
    .wr_data (qt_data),
    .rd_sel  (tsel),
    .rd_addr (pos[5:0]),
    .rd_data (q_rd)
  );

`ifdef JPEG_DC_PRED_EN
  logic signed [COEF_W-1:0] pred_q [3];
  logic [1:0]               pidx;
  logic                     pred_ok;

  assign pidx      = 2'(sym_chan);
  assign pred_ok   = int'(sym_chan) < 3;
  assign level_eff = (first && pred_ok) ? pred_q[pidx] + sym_level : sym_level;

  // restart wins over a same-cycle DC update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) pred_q[i] <= '0;
    end else if (dc_restart) begin
      for (int i = 0; i < 3; i++) pred_q[i] <= '0;
    end else if (acc && first && !sym_eob && pred_ok) begin
      pred_q[pidx] <= level_eff;
    end
  end
`else
  logic unused_dc_restart;
  assign unused_dc_restart = dc_restart;
  assign level_eff         = sym_level;
`endif

  assign lvl_x = P_W'(level_eff);
  assign q_x   = P_W'({1'b0, q_rd});
  assign prod  = lvl_x * q_x;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_FILL: begin
        if (done)     state_d = ST_EMIT;
        else if (acc) state_d = ST_FILL;
      end
      ST_EMIT: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Assembly buffer is indexed in raster order; stale entries are hidden by the mask.
  always_ff @(posedge clk) begin
    if (wr_coef) coef_buf[nat] <= sat_coef(32'(prod));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_q     <= 1'b0;
      k_q       <= '0;
      mask_q    <= '0;
      chan_q    <= '0;
      tsel_q    <= 1'b0;
      blk_out   <= '0;
      chan_out  <= '0;
      valid_out <= 1'b0;
      fmt_err   <= 1'b0;
    end else begin
      rdy_q     <= 1'b1;
      valid_out <= 1'b0;
      fmt_err   <= 1'b0;
      if (acc) begin
        if (first) begin
          chan_q <= sym_chan;
          tsel_q <= tsel;
        end
        if (wr_coef) begin
          mask_q[nat] <= 1'b1;
          k_q         <= pos + 7'd1;
        end
        if (!sym_eob && ovf) fmt_err <= 1'b1;
      end
      if (state_q == ST_EMIT) begin
        for (int r = 0; r < 8; r++) begin
          for (int c = 0; c < 8; c++) begin
            blk_out[3'(r)][3'(c)] <= mask_q[{3'(r), 3'(c)}] ? coef_buf[{3'(r), 3'(c)}] : '0;
          end
        end
        chan_out  <= chan_q;
        valid_out <= 1'b1;
        mask_q    <= '0;
        k_q       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_jpeg_dezigzag_dequant.sv
// Randomised self-checking bench for jpeg_dezigzag_dequant against a zigzag/dequant reference model.
// Honours JPEG_DC_PRED_EN for the DC predictor model.
module tb_jpeg_dezigzag_dequant;

  localparam int CH_W   = 2;
  localparam int COEF_W = 12;
  localparam int Q_W    = 8;

  logic                        clk = 1'b0;
  logic                        rst = 1'b0;
  logic                        sym_valid = 1'b0;
  logic                        sym_ready;
  logic [3:0]                  sym_run = '0;
  logic signed [COEF_W-1:0]    sym_level = '0;
  logic                        sym_eob = 1'b0;
  logic [CH_W-1:0]             sym_chan = '0;
  logic                        dc_restart = 1'b0;
  logic                        qt_wr = 1'b0;
  logic                        qt_sel = 1'b0;
  logic [5:0]                  qt_addr = '0;
  logic [Q_W-1:0]              qt_data = '0;
  logic [7:0][7:0][COEF_W-1:0] blk_out;
  logic [CH_W-1:0]             chan_out;
  logic                        valid_out;
  logic                        fmt_err;

  jpeg_dezigzag_dequant #(.CH_W(CH_W), .COEF_W(COEF_W), .Q_W(Q_W)) dut (
    .clk(clk), .rst(rst), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .sym_run(sym_run), .sym_level(sym_level), .sym_eob(sym_eob), .sym_chan(sym_chan),
    .dc_restart(dc_restart), .qt_wr(qt_wr), .qt_sel(qt_sel), .qt_addr(qt_addr),
    .qt_data(qt_data), .blk_out(blk_out), .chan_out(chan_out),
    .valid_out(valid_out), .fmt_err(fmt_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int zz_nat [64];
  int qt_m [2][64];
  int pred_m [3];
  int sq_run [$];
  int sq_lvl [$];
  bit sq_eob [$];
  int exp_blk [64];
  bit exp_ovf;

  // zigzag order walks anti-diagonals, alternating direction
  function automatic void build_zigzag();
    int idx = 0;
    for (int s = 0; s < 15; s++) begin
      for (int j = 0; j < 8; j++) begin
        int r = (s % 2 == 0) ? 7 - j : j;
        int c = s - r;
        if (c >= 0 && c < 8) begin
          zz_nat[idx] = r * 8 + c;
          idx++;
        end
      end
    end
  endfunction

  function automatic int sat(input int v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  function automatic int wrap12(input int v);
    int w = v & 32'hFFF;
    return (w >= 2048) ? w - 4096 : w;
  endfunction

  function automatic void model_block(input int chan);
    int zz [64];
    int k = 0;
    exp_ovf = 1'b0;
    for (int i = 0; i < 64; i++) zz[i] = 0;
    for (int i = 0; i < sq_run.size(); i++) begin
      int lvl = sq_lvl[i];
      int p;
      if (sq_eob[i]) break;
`ifdef JPEG_DC_PRED_EN
      if (i == 0 && chan < 3) begin
        lvl = wrap12(pred_m[chan] + lvl);
        pred_m[chan] = lvl;
      end
`endif
      p = k + sq_run[i];
      if (p > 63) begin
        exp_ovf = 1'b1;
        break;
      end
      zz[p] = sat(lvl * qt_m[(chan != 0) ? 1 : 0][p]);
      k = p + 1;
      if (p == 63) break;
    end
    for (int i = 0; i < 64; i++) exp_blk[zz_nat[i]] = zz[i];
  endfunction

  function automatic void clear_q();
    sq_run.delete();
    sq_lvl.delete();
    sq_eob.delete();
  endfunction

  function automatic void push_sym(input int run, input int lvl, input bit eob);
    sq_run.push_back(run);
    sq_lvl.push_back(lvl);
    sq_eob.push_back(eob);
  endfunction

  task automatic qt_write(input int sel, input int addr, input int data);
    qt_wr   = 1'b1;
    qt_sel  = sel[0];
    qt_addr = 6'(addr);
    qt_data = 8'(data);
    @(posedge clk); #1;
    qt_wr = 1'b0;
    qt_m[sel][addr] = data;
  endtask

  task automatic pulse_restart();
    dc_restart = 1'b1;
    @(posedge clk); #1;
    dc_restart = 1'b0;
`ifdef JPEG_DC_PRED_EN
    for (int i = 0; i < 3; i++) pred_m[i] = 0;
`endif
  endtask

  task automatic send(input int run, input int lvl, input bit eob, input int chan);
    int n = 0;
    sym_valid = 1'b1;
    sym_run   = 4'(run);
    sym_level = 12'(lvl);
    sym_eob   = eob;
    sym_chan  = 2'(chan);
    @(negedge clk);
    while (!sym_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL send_timeout: sym_ready=%0b after %0d cycles, required 1", sym_ready, n);
    end
    @(posedge clk); #1;
    sym_valid = 1'b0;
  endtask

  task automatic check_blk(input string name);
    int bad = 0;
    for (int i = 0; i < 64; i++) begin
      logic signed [COEF_W-1:0] a;
      a = blk_out[i / 8][i % 8];
      if (int'(a) !== exp_blk[i]) begin
        bad++;
        if (bad <= 4)
          $display("FAIL %s blk[%0d][%0d]: got %0d, required %0d", name, i / 8, i % 8, a, exp_blk[i]);
      end
    end
    checks++;
    if (bad != 0) errors++;
  endtask

  // sends the queued block; later symbols carry a random channel to prove only the first is sampled
  task automatic run_block(input string name, input int chan);
    model_block(chan);
    for (int i = 0; i < sq_run.size(); i++)
      send(sq_run[i], sq_lvl[i], sq_eob[i], (i == 0) ? chan : int'($urandom_range(0, 3)));
    checks++;
    if (fmt_err !== exp_ovf) begin
      errors++;
      $display("FAIL %s fmt_err: got %0b, required %0b", name, fmt_err, exp_ovf);
    end
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL %s early_valid: got %0b, required 0", name, valid_out);
    end
    @(posedge clk); #1;
    checks++;
    if (valid_out !== 1'b1) begin
      errors++;
      $display("FAIL %s valid_out: got %0b, required 1", name, valid_out);
    end
    check_blk(name);
    checks++;
    if (int'(chan_out) !== chan) begin
      errors++;
      $display("FAIL %s chan_out: got %0d, required %0d", name, chan_out, chan);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (valid_out !== 1'b0 || fmt_err !== 1'b0 || sym_ready !== 1'b0 || chan_out !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: valid=%0b err=%0b ready=%0b chan=%0d, required all 0",
               valid_out, fmt_err, sym_ready, chan_out);
    end
    for (int i = 0; i < 64; i++) exp_blk[i] = 0;
    check_blk("reset_blk");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 64; i++) qt_write(0, i, 1);
    clear_q();
    push_sym(0, 5, 0);
    push_sym(0, 0, 1);
    run_block("basic", 0);
    checks++;
    if ($signed(blk_out[0][0]) !== 12'sd5) begin
      errors++;
      $display("FAIL basic_dc: got %0d, required 5", $signed(blk_out[0][0]));
    end
    @(posedge clk); #1;
    checks++;
    if (valid_out !== 1'b0 || $signed(blk_out[0][0]) !== 12'sd5) begin
      errors++;
      $display("FAIL basic_hold: valid=%0b dc=%0d, required valid 0 dc 5", valid_out, $signed(blk_out[0][0]));
    end
  endtask

  task automatic test_chan_table();
    qt_write(1, 0, 7);
    qt_write(1, 1, 16);
    clear_q();
    push_sym(0, 1, 0);
    push_sym(0, -3, 0);
    push_sym(0, 0, 1);
    run_block("chan_table", 2);
    checks++;
    if ($signed(blk_out[0][1]) !== -12'sd48 || $signed(blk_out[0][0]) !== 12'sd7) begin
      errors++;
      $display("FAIL chan_table_lit: got [0][0]=%0d [0][1]=%0d, required 7 and -48",
               $signed(blk_out[0][0]), $signed(blk_out[0][1]));
    end
  endtask

  task automatic test_full_block();
    clear_q();
    for (int k = 0; k < 64; k++) push_sym(0, k, 0);
    run_block("full_block", 0);
  endtask

`ifdef JPEG_DC_PRED_EN
  task automatic test_dc_pred();
    int exp_dc [3] = '{10, 15, 3};
    int diff [3] = '{10, 5, 3};
    pulse_restart();
    for (int b = 0; b < 3; b++) begin
      if (b == 2) pulse_restart();
      clear_q();
      push_sym(0, diff[b], 0);
      push_sym(0, 0, 1);
      run_block("dc_pred", 0);
      checks++;
      if ($signed(blk_out[0][0]) !== 12'(exp_dc[b])) begin
        errors++;
        $display("FAIL dc_pred_lit: got %0d, required %0d", $signed(blk_out[0][0]), exp_dc[b]);
      end
    end
  endtask
`endif

  task automatic test_saturation();
    pulse_restart();
    qt_write(0, 0, 255);
    qt_write(0, 1, 2);
    clear_q();
    push_sym(0, 2047, 0);
    push_sym(0, -2048, 0);
    push_sym(0, 0, 1);
    run_block("saturation", 0);
    checks++;
    if ($signed(blk_out[0][0]) !== 12'sd2047 || $signed(blk_out[0][1]) !== -12'sd2048) begin
      errors++;
      $display("FAIL saturation_lit: got %0d,%0d, required 2047,-2048",
               $signed(blk_out[0][0]), $signed(blk_out[0][1]));
    end
  endtask

  task automatic test_overflow();
    clear_q();
    push_sym(0, 1, 0);
    for (int i = 0; i < 4; i++) push_sym(15, 1, 0);
    run_block("overflow", 1);
    clear_q();
    push_sym(2, 9, 0);
    push_sym(0, 0, 1);
    run_block("after_overflow", 1);
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    clear_q();
    for (int i = 0; i < 10; i++) send(0, i + 1, 0, 1);
    rst = 1'b0;
    #1;
    checks++;
    if (valid_out !== 1'b0 || sym_ready !== 1'b0 || chan_out !== '0) begin
      errors++;
      $display("FAIL reset_mid_ctrl: valid=%0b ready=%0b chan=%0d, required 0", valid_out, sym_ready, chan_out);
    end
    for (int i = 0; i < 64; i++) exp_blk[i] = 0;
    check_blk("reset_mid_blk");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) pred_m[i] = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (valid_out) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_mid_pulse: valid_out seen=1, required 0");
    end
    clear_q();
    push_sym(1, 7, 0);
    push_sym(3, -2, 0);
    push_sym(0, 0, 1);
    run_block("reset_mid_clean", 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 64; i++) begin
      qt_write(0, i, $urandom_range(0, 255));
      qt_write(1, i, $urandom_range(0, 255));
    end
    for (int b = 0; b < 24; b++) begin
      int k = 0;
      int chan = $urandom_range(0, 2);
      clear_q();
      for (int n = 0; n < 70; n++) begin
        int run;
        if ((n == 0 && $urandom_range(0, 15) == 0) || (n > 0 && $urandom_range(0, 11) == 0)) begin
          push_sym($urandom_range(0, 15), 0, 1);
          break;
        end
        run = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
        push_sym(run, int'($urandom_range(0, 4095)) - 2048, 0);
        if (k + run >= 63) break;
        k = k + run + 1;
      end
      run_block("random", chan);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    build_zigzag();
    for (int i = 0; i < 3; i++) pred_m[i] = 0;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 64; i++) qt_m[s][i] = 0;
    test_reset();
    test_basic();
    test_chan_table();
    test_full_block();
`ifdef JPEG_DC_PRED_EN
    test_dc_pred();
`endif
    test_saturation();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
